div_share_arbiter: RTL and testbench

Shares one iterative `divider` instance (N-bit unsigned, non-restoring) between NUM_REQ requesters, e.g. the per-thread ALUs of a core. Requests are granted round-robin, operands are issued with a one-cycle `start`, and the block waits for `done`. The quotient is returned to the granted requester over a valid/ready response channel. The block instantiates the divider behind it; requesters never touch the divider directly.

---
 rtl/div_arb_pkg.sv | 28 ++
 rtl/div_share_arbiter_if.sv | 28 ++
 rtl/divider.sv | 77 +++++++
 rtl/rr_arbiter.sv | 34 +++
 rtl/div_share_arbiter.sv | 132 +++++++++++++
 tb/tb_div_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider-sharing arbiter.
// Holds the FSM state encodings, default sizes and a width helper.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DEF_N       = 8;
  localparam int DEF_NUM_REQ = 4;

  // Wide enough to slice down to any practical operand width.
  localparam logic [63:0] ALL_ONES = '1;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared divider block.
interface div_share_arbiter_if
  import div_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_REQ = DEF_NUM_REQ
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][N-1:0] req_dividend;
  logic [NUM_REQ-1:0][N-1:0] req_divisor;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [N-1:0]              rsp_quotient;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic                      busy;

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, busy
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, busy
  );

endinterface

// File: rtl/divider.sv
// Iterative N-bit unsigned non-restoring divider: one quotient bit per cycle,
// done pulses for one cycle after N RUN cycles. Divisor 0 yields all-ones.
module divider
  import div_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         done_o,
  output logic [N-1:0] quotient_o
);

  localparam int CNT_W = idx_width(N);

  div_state_t       state_q, state_d;
  logic [N+1:0]     rem_q, rem_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N+1:0]     shifted;
  logic [N+1:0]     dvs_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Quotient register doubles as the dividend shift register; the partial
  // remainder's sign picks add-back or subtract for the next step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    shifted = {rem_q[N:0], quo_q[N-1]};
    dvs_ext = {2'b00, dvs_q};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          rem_d   = '0;
          quo_d   = dividend_i;
          dvs_d   = divisor_i;
          cnt_d   = CNT_W'(N - 1);
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        rem_d = rem_q[N+1] ? (shifted + dvs_ext) : (shifted - dvs_ext);
        quo_d = {quo_q[N-2:0], ~rem_d[N+1]};
        if (cnt_q == '0) state_d = DIV_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign done_o     = (state_q == DIV_DONE);
  assign quotient_o = quo_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping around.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_valid_o
);

  int pos;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    pos         = 0;
    idx_o       = '0;
    any_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req_i[pos]) begin
        any_valid_o = 1'b1;
        idx_o       = IDX_W'(pos);
      end
    end
    grant_o = any_valid_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_o) : '0;
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider among NUM_REQ requesters with round-robin grants.
// Define DIV_ZERO_BYPASS_EN to answer divide-by-zero directly without the divider.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input logic                clk,
  input logic                reset,
  div_share_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [N-1:0]       dvs_q, dvs_d;
  logic [N-1:0]       quo_q, quo_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               div_start;
  logic               div_done;
  logic [N-1:0]       div_quotient;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [N-1:0]       rsp_quotient;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i       (bus.req_valid),
    .ptr_i       (rr_q),
    .grant_o     (arb_grant),
    .idx_o       (arb_idx),
    .any_valid_o (arb_any)
  );

  divider #(
    .N (N)
  ) u_divider (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .dividend_i (dvd_q),
    .divisor_i  (dvs_q),
    .done_o     (div_done),
    .quotient_o (div_quotient)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
    end
  end

  // The grant only ever lands on a valid index, so any grant is a handshake.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rr_d         = rr_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    quo_d        = quo_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_quotient = '0;
    div_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          req_ready = arb_grant;
          idx_d     = arb_idx;
          dvd_d     = bus.req_dividend[arb_idx];
          dvs_d     = bus.req_divisor[arb_idx];
`ifdef DIV_ZERO_BYPASS_EN
          if (bus.req_divisor[arb_idx] == '0) begin
            quo_d   = ALL_ONES[N-1:0];
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          quo_d   = div_quotient;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid    = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
        rsp_quotient = quo_q;
        if (bus.rsp_ready[idx_q]) begin
          rr_d    = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_quotient = rsp_quotient;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: a scoreboard of expected
// quotients/latencies plus grant-order logs, checked with immediate assertions.
module tb_div_share_arbiter;

  localparam int N       = 8;
  localparam int NUM_REQ = 4;
  localparam int LAT     = N + 3;

  typedef struct {
    int           idx;
    logic [N-1:0] quo;
    int           acc;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  div_share_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

  div_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t               sb[$];
  int                 grantLog[$];
  int                 expOrder[$];
  int                 compared   = 0;
  int                 mismatched = 0;
  int                 cyc        = 0;
  logic [NUM_REQ-1:0] reqValid;
  logic [NUM_REQ-1:0] rspReady;
  logic [N-1:0]       dvd[NUM_REQ];
  logic [N-1:0]       dvs[NUM_REQ];
  int                 remaining[NUM_REQ];
  logic               checkIdleNext;

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [N-1:0] modelQuo(logic [N-1:0] a, logic [N-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic int modelLat(logic [N-1:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    return (b == '0) ? 1 : LAT;
`else
    return (b == '0) ? LAT : LAT;
`endif
  endfunction

  task automatic drive();
    bus.req_valid = reqValid;
    bus.rsp_ready = rspReady;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_dividend[i] = dvd[i];
      bus.req_divisor[i]  = dvs[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(int i, logic [N-1:0] a, logic [N-1:0] b, int count);
    dvd[i]       = a;
    dvs[i]       = b;
    remaining[i] = count;
    reqValid[i]  = 1'b1;
    drive();
  endtask

  // Observe one cycle: record grants, score responses, then advance the clock.
  task automatic step();
    logic [NUM_REQ-1:0] hs;
    logic [NUM_REQ-1:0] rh;
    exp_t e;
    drive();
    #1;
    if (checkIdleNext) begin
      checkOutput("busy_after_rsp", 32'(bus.busy), 32'd0);
      checkIdleNext = 1'b0;
    end
    if (bus.busy) checkOutput("ready_while_busy", 32'(bus.req_ready), 32'd0);
    hs = reqValid & bus.req_ready;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        e.idx = i;
        e.quo = modelQuo(dvd[i], dvs[i]);
        e.acc = cyc;
        e.lat = modelLat(dvs[i]);
        sb.push_back(e);
        grantLog.push_back(i);
      end
    end
    rh = bus.rsp_valid & rspReady;
    if (rh != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_valid_onehot", 32'(bus.rsp_valid), 32'd1 << e.idx);
        checkOutput("rsp_quotient", 32'(bus.rsp_quotient), 32'(e.quo));
        checkOutput("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        checkIdleNext = 1'b1;
      end
    end
    tick();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i] && reqValid[i]) begin
        remaining[i]--;
        if (remaining[i] <= 0) begin
          reqValid[i] = 1'b0;
        end else begin
          dvd[i] = dvd[i] + N'(17);
          dvs[i] = dvs[i] + N'(1);
        end
      end
    end
  endtask

  task automatic runUntilIdle(string tag, int budget);
    int n = 0;
    while (((reqValid != '0) || (sb.size() != 0) || bus.busy) && (n < budget)) begin
      step();
      n++;
    end
    checkOutput({tag, "_done_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic checkOrder(string tag);
    checkOutput({tag, "_count"}, 32'(grantLog.size()), 32'(expOrder.size()));
    for (int k = 0; k < expOrder.size() && k < grantLog.size(); k++)
      checkOutput($sformatf("%s_%0d", tag, k), 32'(grantLog[k]), 32'(expOrder[k]));
  endtask

  task automatic doReset();
    reqValid = '0;
    rspReady = '1;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
    drive();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
    grantLog.delete();
    checkIdleNext = 1'b0;
  endtask

  initial begin
    int n;
    reset         = 1'b1;
    reqValid      = '0;
    rspReady      = '1;
    checkIdleNext = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dvd[i]       = '0;
      dvs[i]       = '0;
      remaining[i] = 0;
    end
    drive();
    tick();
    tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_quotient", 32'(bus.rsp_quotient), 32'd0);
    reset = 1'b0;

    $display("[TB] single request 100/7");
    applyStimulus(0, 8'd100, 8'd7, 1);
    #1;
    checkOutput("single_ready_same_cycle", 32'(bus.req_ready), 32'h1);
    runUntilIdle("single", 40);

    $display("[TB] round-robin 0,2,3 then wrap");
    doReset();
    applyStimulus(0, 8'd200, 8'd10, 1);
    applyStimulus(2, 8'd255, 8'd3, 1);
    applyStimulus(3, 8'd9, 8'd9, 1);
    runUntilIdle("rr", 80);
    expOrder = '{0, 2, 3};
    checkOrder("rr_order");
    grantLog.delete();
    applyStimulus(0, 8'd7, 8'd2, 1);
    applyStimulus(1, 8'd6, 8'd3, 1);
    runUntilIdle("rr_wrap", 60);
    expOrder = '{0, 1};
    checkOrder("rr_wrap_order");

    $display("[TB] fairness with four continuous requesters");
    doReset();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, N'(40 * i + 13), N'(i + 2), 2);
    runUntilIdle("fair", 200);
    expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkOrder("fair_order");

    $display("[TB] response backpressure on requester 1");
    grantLog.delete();
    rspReady = 4'b1101;
    applyStimulus(1, 8'd77, 8'd7, 1);
    n = 0;
    while ((bus.rsp_valid[1] !== 1'b1) && (n < 40)) begin
      step();
      n++;
    end
    checkOutput("bp_rsp_reached", 32'(n < 40), 32'd1);
    applyStimulus(0, 8'd90, 8'd9, 1);
    applyStimulus(2, 8'd33, 8'd4, 1);
    for (int k = 0; k < 20; k++) begin
      drive();
      #1;
      checkOutput("bp_valid_held", 32'(bus.rsp_valid), 32'h2);
      checkOutput("bp_quotient_held", 32'(bus.rsp_quotient), 32'd11);
      checkOutput("bp_no_grant", 32'(bus.req_ready), 32'd0);
      tick();
    end
    if (sb.size() > 0) sb[0].lat = sb[0].lat + 20;
    rspReady = '1;
    runUntilIdle("bp", 80);
    expOrder = '{1, 2, 0};
    checkOrder("bp_order");

    $display("[TB] divide by zero 5/0");
    grantLog.delete();
    applyStimulus(2, 8'd5, 8'd0, 1);
    runUntilIdle("dz", 40);

    $display("[TB] reset during WAIT");
    applyStimulus(2, 8'd123, 8'd4, 1);
    n = 0;
    while (!bus.busy && (n < 10)) begin
      step();
      n++;
    end
    repeat (5) step();
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midreset_rsp_quotient", 32'(bus.rsp_quotient), 32'd0);
    checkOutput("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    checkIdleNext = 1'b0;
    tick();
    reset = 1'b0;
    grantLog.delete();
    applyStimulus(3, 8'd63, 8'd7, 1);
    applyStimulus(0, 8'd50, 8'd5, 1);
    runUntilIdle("post_reset", 80);
    expOrder = '{0, 3};
    checkOrder("post_reset_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
